// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam logic [31:0]     INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    localparam fq_entry_t FQ_EMPTY_ENTRY = '{inst: INST_NOP, pc: '0};

endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO of fetched instructions with a registered head entry.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_nxt;
    logic [PW:0]     remain;
    logic [PW:0]     count_nxt;
    fq_entry_t       head_nxt;

    // The head register is loaded with whatever will be the oldest entry after this
    // edge; an entry pushed into an otherwise-empty queue bypasses storage.
    always_comb begin
        remain    = count - (PW+1)'(pop);
        count_nxt = remain + (PW+1)'(push);
        rd_nxt    = rd_ptr + PW'(pop);
        head_nxt  = FQ_EMPTY_ENTRY;
        if (remain != '0) begin
            head_nxt = mem[rd_nxt];
        end else if (push) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= FQ_EMPTY_ENTRY;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_nxt;
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            head       <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, reads imem, queues instructions for decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int unsigned     IMEM_AW  = 10,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_inst,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_pc4
);

    localparam int unsigned     CW         = $clog2(FQ_DEPTH) + 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           inflight_pc;
    logic                      inflight;
    logic                      pop;
    logic                      push;
    logic                      issue;
    logic [CW-1:0]             occupancy;
    logic [$clog2(FQ_DEPTH):0] fq_count;
    logic                      head_valid;
    fq_entry_t                 head;
    fq_entry_t                 push_data;

    assign pop = head_valid & id_ready;

    // A redirect kills the response arriving this cycle; the queue flush covers the rest.
    assign push      = inflight & !redirect_valid;
    assign push_data = '{inst: imem_rdata, pc: inflight_pc};

    // Credit check: queued + in-flight entries, less the one leaving now, must leave room.
    always_comb begin
        occupancy = CW'(fq_count) + CW'(inflight) - CW'(pop);
        issue     = !rst && !redirect_valid && (occupancy < CW'(FQ_DEPTH));
    end

    assign imem_en   = issue;
    assign imem_addr = pc[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (fq_count)
    );

    assign id_valid = head_valid;
    assign id_inst  = head.inst;
    assign id_pc    = head.pc;
    assign id_pc4   = head_valid ? head.pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random traffic vs. model.
module tb_fetch_unit;

    localparam int unsigned FQ_DEPTH = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic        mon_on = 1'b0;

    logic [31:0] imem [1024];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .IMEM_AW  (10),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 | 32'(i);
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [9:0] idx;
        idx = pc[11:2];
        return 32'h1000_0000 | 32'(idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each issued PC is remembered with its issue cycle; the oldest
    // one becomes visible to decode two cycles later and leaves on a handshake.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } issued_t;

    issued_t     mq[$];
    logic [31:0] mpc = '0;
    int          mcyc = 0;

    always @(negedge clk) begin
        if (mon_on) begin : model
            logic exp_valid;
            logic exp_pop;
            logic exp_en;
            exp_valid = (mq.size() > 0) && (mq[0].cyc + 2 <= mcyc);
            check("mon_id_valid", 32'(id_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("mon_id_pc", id_pc, mq[0].pc);
                check("mon_id_inst", id_inst, word_at(mq[0].pc));
                check("mon_id_pc4", id_pc4, mq[0].pc + 32'd4);
            end else begin
                check("mon_idle_inst", id_inst, NOP);
                check("mon_idle_pc", id_pc, 32'h0);
                check("mon_idle_pc4", id_pc4, 32'h0);
            end
            exp_pop = exp_valid && id_ready;
            exp_en  = !rst && !redirect_valid &&
                      ((mq.size() - (exp_pop ? 1 : 0)) < FQ_DEPTH);
            check("mon_imem_en", 32'(imem_en), 32'(exp_en));
            check("mon_imem_addr", 32'(imem_addr), 32'(mpc[11:2]));
            if (rst) begin
                mq.delete();
                mpc = 32'h0;
            end else if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (exp_pop) void'(mq.pop_front());
                if (exp_en) begin
                    mq.push_back('{pc: mpc, cyc: mcyc});
                    mpc = mpc + 32'd4;
                end
            end
            mcyc++;
        end
    end

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        en;
        logic [9:0]  addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [18];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int unsigned limit);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!id_valid && n < limit) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        if (!id_valid) check("wait_valid_timeout", 32'(id_valid), 32'h1);
    endtask

    initial begin
        logic [9:0]  w_addr [5];
        logic        w_valid [5];
        logic [31:0] w_pc [5];

        // Start-up stream, 6-cycle stall, then redirect to 0x40.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h000, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h001, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h002, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h003, 1'b1, 32'h4};
        for (int i = 4; i < 10; i++)
            tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h004, 1'b1, 32'h8};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h004, 1'b1, 32'h8};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h005, 1'b1, 32'hC};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h006, 1'b1, 32'h10};
        tbl[13] = '{1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 10'h007, 1'b1, 32'h14};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h010, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h011, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h012, 1'b1, 32'h40};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 10'h013, 1'b1, 32'h44};

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        next_cycle();
        mon_on = 1'b1;
        next_cycle();

        for (int i = 0; i < 18; i++) begin
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            id_ready       = tbl[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
            check($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            check($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_id_pc", i), id_pc, tbl[i].pc);
            check($sformatf("vec%0d_id_inst", i), id_inst,
                  tbl[i].valid ? word_at(tbl[i].pc) : NOP);
            check($sformatf("vec%0d_id_pc4", i), id_pc4,
                  tbl[i].valid ? tbl[i].pc + 32'd4 : 32'h0);
            next_cycle();
        end

        // Fill the queue with decode stalled, then redirect to a misaligned target.
        id_ready = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("full_id_valid", 32'(id_valid), 32'h1);
        check("full_id_pc", id_pc, 32'h48);
        check("full_imem_en", 32'(imem_en), 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        next_cycle();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        check("flush_id_valid", 32'(id_valid), 32'h0);
        next_cycle();
        wait_valid(6);
        check("misalign_id_pc", id_pc, 32'h100);
        check("misalign_id_inst", id_inst, 32'h1000_0040);
        next_cycle();

        // Reset coinciding with a redirect: reset wins.
        repeat (4) next_cycle();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        next_cycle();
        rst = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_imem_en", 32'(imem_en), 32'h1);
        check("rst_imem_addr", 32'(imem_addr), 32'h0);
        next_cycle();
        wait_valid(6);
        check("rst_refetch_pc", id_pc, 32'h0);
        check("rst_refetch_inst", id_inst, 32'h1000_0000);
        next_cycle();

        // Redirect near the top of the address space: PC and imem_addr wrap.
        w_addr  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};
        w_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w_pc    = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wrap%0d_imem_addr", k), 32'(imem_addr), 32'(w_addr[k]));
            check($sformatf("wrap%0d_id_valid", k), 32'(id_valid), 32'(w_valid[k]));
            check($sformatf("wrap%0d_id_pc", k), id_pc, w_pc[k]);
            next_cycle();
        end

        // Random traffic against the reference model.
        repeat (3000) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = $urandom;
            id_ready       = ($urandom_range(0, 99) < 70);
            next_cycle();
        end

        rst = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
